// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: skid FSM states,
// per-stage payload widths and the MEM/WB payload layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // MEM/WB payload as packed by the MEM stage; the first field lands in the MSBs.
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wb_reg_num;
    logic        reg_write;
    logic        lo_write;
    logic        hi_write;
  } memwb_t;

  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 32 * 4 + 5 + 6;
  localparam int EXMEM_W = 32 * 4 + 5 + 3;
  localparam int MEMWB_W = $bits(memwb_t);

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Handshake controller for pipe_stage_reg: state register, in_ready decode
// and load enables for the main (M) and skid (S) payload registers.
module pipe_skid_ctrl
  import pipe_pkg::*;
#(
  parameter int SKID = 1
) (
  input  logic clk,
  input  logic CLR,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic load_m_in,
  output logic load_m_skid,
  output logic load_s,
  output logic clear_regs
);

  skid_state_e state_q, state_d;
  logic        in_fire, out_fire;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // With SKID, in_ready depends only on the state register, never on out_ready.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    if (SKID != 0) in_ready = (state_q != ST_FULL);
    else           in_ready = out_ready | (state_q == ST_EMPTY);
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    clear_regs  = 1'b0;
    in_fire     = in_valid & in_ready;
    out_fire    = out_valid & out_ready;
    if (flush) begin
      state_d    = ST_EMPTY;
      clear_regs = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d   = ST_ONE;
            load_m_in = 1'b1;
          end
        end
        ST_ONE: begin
          // Without SKID, in_fire in ONE implies out_fire, so FULL is unreachable.
          if (in_fire && out_fire) begin
            load_m_in = 1'b1;
          end else if (in_fire) begin
            state_d = ST_FULL;
            load_s  = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d     = ST_ONE;
            load_m_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register: opaque payload with valid/ready,
// synchronous flush, optional two-entry skid buffer and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] m_q, s_q;
  logic              load_m_in, load_m_skid, load_s, clear_regs;

  pipe_skid_ctrl #(.SKID(SKID)) u_ctrl (
    .clk        (clk),
    .CLR        (CLR),
    .flush      (flush),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .load_m_in  (load_m_in),
    .load_m_skid(load_m_skid),
    .load_s     (load_s),
    .clear_regs (clear_regs)
  );

  // NOTE: payload registers are reset on purpose: out_data must read 0 during reset.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      m_q <= '0;
      s_q <= '0;
    end else if (clear_regs) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_m_in)        m_q <= in_data;
      else if (load_m_skid) m_q <= s_q;
      if (load_s)           s_q <= in_data;
    end
  end

  assign out_data = m_q;

  // Counts back-pressured cycles; flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid and non-skid instances plus a
// narrow-counter instance for saturation.
module tb_pipe_stage_reg;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
  } vec_t;

  logic        clk = 1'b0;
  logic        CLR;
  logic        fl1, iv1, ordy1, fl0, iv0, ordy0;
  logic [31:0] id1, id0;
  logic        ir1, ov1, ir0, ov0, ir4, ov4;
  logic [31:0] od1, od0, od4;
  logic [15:0] cnt1, cnt0;
  logic [3:0]  cnt4;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t tbl1[$];
  vec_t tbl0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .CLR(CLR), .flush(fl1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .stall_cnt(cnt1));

  pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .CLR(CLR), .flush(fl0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .stall_cnt(cnt0));

  pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(4)) dut4 (
    .clk(clk), .CLR(CLR), .flush(fl1), .in_valid(iv1), .in_ready(ir4), .in_data(id1),
    .out_valid(ov4), .out_ready(ordy1), .out_data(od4), .stall_cnt(cnt4));

  function automatic vec_t mk(logic fl, logic iv, logic [31:0] id, logic ordy,
                              logic e_ir, logic e_ov, logic [31:0] e_od);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one vector after the falling edge, check outputs mid-cycle; the
  // following rising edge consumes the vector.
  task automatic apply(input vec_t v, input bit sel0, input int idx);
    @(negedge clk);
    if (sel0) begin
      fl0 = v.fl; iv0 = v.iv; id0 = v.id; ordy0 = v.ordy;
    end else begin
      fl1 = v.fl; iv1 = v.iv; id1 = v.id; ordy1 = v.ordy;
    end
    #1;
    if (sel0) begin
      check($sformatf("skid0 v%0d in_ready", idx), {31'd0, ir0}, {31'd0, v.e_ir});
      check($sformatf("skid0 v%0d out_valid", idx), {31'd0, ov0}, {31'd0, v.e_ov});
      if (v.e_ov) check($sformatf("skid0 v%0d out_data", idx), od0, v.e_od);
    end else begin
      check($sformatf("skid1 v%0d in_ready", idx), {31'd0, ir1}, {31'd0, v.e_ir});
      check($sformatf("skid1 v%0d out_valid", idx), {31'd0, ov1}, {31'd0, v.e_ov});
      if (v.e_ov) check($sformatf("skid1 v%0d out_data", idx), od1, v.e_od);
    end
  endtask

  initial begin
    // Streaming 0x1..0x8 with out_ready held high.
    tbl1.push_back(mk(0, 1, 32'h1, 1, 1, 0, 0));
    for (int k = 2; k <= 8; k++) tbl1.push_back(mk(0, 1, k, 1, 1, 1, k - 1));
    tbl1.push_back(mk(0, 0, 0, 1, 1, 1, 32'h8));
    tbl1.push_back(mk(0, 0, 0, 1, 1, 0, 0));
    // Back-pressure: 0x11 lands in S, 0x12 waits upstream; 3 stalled cycles.
    tbl1.push_back(mk(0, 1, 32'h10, 1, 1, 0, 0));
    tbl1.push_back(mk(0, 1, 32'h11, 0, 1, 1, 32'h10));
    tbl1.push_back(mk(0, 1, 32'h12, 0, 0, 1, 32'h10));
    tbl1.push_back(mk(0, 1, 32'h12, 0, 0, 1, 32'h10));
    tbl1.push_back(mk(0, 1, 32'h12, 1, 0, 1, 32'h10));
    tbl1.push_back(mk(0, 1, 32'h12, 1, 1, 1, 32'h11));
    tbl1.push_back(mk(0, 0, 0, 1, 1, 1, 32'h12));
    tbl1.push_back(mk(0, 0, 0, 1, 1, 0, 0));
    // Flush from FULL with 0x55 offered: 2 more stalled cycles, 0x55 never emerges.
    tbl1.push_back(mk(0, 1, 32'h20, 0, 1, 0, 0));
    tbl1.push_back(mk(0, 1, 32'h21, 0, 1, 1, 32'h20));
    tbl1.push_back(mk(1, 1, 32'h55, 0, 0, 1, 32'h20));
    tbl1.push_back(mk(0, 0, 0, 1, 1, 0, 0));
    tbl1.push_back(mk(0, 1, 32'h30, 1, 1, 0, 0));
    tbl1.push_back(mk(0, 0, 0, 1, 1, 1, 32'h30));
    tbl1.push_back(mk(0, 0, 0, 1, 1, 0, 0));
    // Flush coinciding with out_fire: 0x40 is delivered, then empty.
    tbl1.push_back(mk(0, 1, 32'h40, 1, 1, 0, 0));
    tbl1.push_back(mk(1, 0, 0, 1, 1, 1, 32'h40));
    tbl1.push_back(mk(0, 0, 0, 1, 1, 0, 0));

    // SKID=0: in_ready follows out_ready combinationally; replace without a bubble.
    tbl0.push_back(mk(0, 1, 32'h60, 0, 1, 0, 0));
    tbl0.push_back(mk(0, 1, 32'h61, 0, 0, 1, 32'h60));
    tbl0.push_back(mk(0, 1, 32'h61, 1, 1, 1, 32'h60));
    tbl0.push_back(mk(0, 0, 0, 1, 1, 1, 32'h61));
    tbl0.push_back(mk(0, 0, 0, 1, 1, 0, 0));

    CLR = 1'b1;
    fl1 = 0; iv1 = 0; id1 = 0; ordy1 = 0;
    fl0 = 0; iv0 = 0; id0 = 0; ordy0 = 0;
    #3;
    check("reset out_valid", {31'd0, ov1}, 32'd0);
    check("reset out_data", od1, 32'd0);
    check("reset in_ready", {31'd0, ir1}, 32'd1);
    check("reset stall_cnt", {16'd0, cnt1}, 32'd0);
    check("reset skid0 in_ready", {31'd0, ir0}, 32'd1);
    @(negedge clk);
    CLR = 1'b0;

    for (int i = 0; i < tbl1.size(); i++) apply(tbl1[i], 1'b0, i);
    @(negedge clk);
    iv1 = 0; fl1 = 0; ordy1 = 1;
    #1;
    check("skid1 stall_cnt after table", {16'd0, cnt1}, 32'd5);
    check("cnt4 stall_cnt after table", {28'd0, cnt4}, 32'd5);

    for (int i = 0; i < tbl0.size(); i++) apply(tbl0[i], 1'b1, i);
    @(negedge clk);
    iv0 = 0; ordy0 = 1;
    #1;
    check("skid0 stall_cnt", {16'd0, cnt0}, 32'd1);

    // Reset mid-stream from FULL (M=0xA, S=0xB), asserted between edges.
    @(negedge clk);
    iv1 = 1; id1 = 32'hA; ordy1 = 0;
    @(negedge clk);
    id1 = 32'hB;
    @(negedge clk);
    iv1 = 0;
    #1;
    check("full in_ready", {31'd0, ir1}, 32'd0);
    check("full out_data", od1, 32'hA);
    check("full stall_cnt", {16'd0, cnt1}, 32'd6);
    CLR = 1'b1;
    #1;
    check("midreset out_valid", {31'd0, ov1}, 32'd0);
    check("midreset out_data", od1, 32'd0);
    check("midreset in_ready", {31'd0, ir1}, 32'd1);
    check("midreset stall_cnt", {16'd0, cnt1}, 32'd0);
    check("midreset cnt4", {28'd0, cnt4}, 32'd0);
    check("midreset cnt4 dut out_valid", {31'd0, ov4}, 32'd0);
    check("midreset cnt4 dut in_ready", {31'd0, ir4}, 32'd1);
    check("midreset cnt4 dut out_data", od4, 32'd0);
    @(negedge clk);
    CLR = 1'b0;
    iv1 = 1; id1 = 32'hC; ordy1 = 1;
    @(negedge clk);
    iv1 = 0; ordy1 = 0;
    #1;
    check("post-reset first accept out_valid", {31'd0, ov1}, 32'd1);
    check("post-reset first accept out_data", od1, 32'hC);

    // Hold a stall for 20 cycles: 4-bit counter saturates at 15.
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    check("sat cnt4 after 20", {28'd0, cnt4}, 32'd15);
    check("sat cnt16 after 20", {16'd0, cnt1}, 32'd20);
    check("stalled out_data stable", od1, 32'hC);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("sat cnt4 holds", {28'd0, cnt4}, 32'd15);
    check("sat cnt16 after 23", {16'd0, cnt1}, 32'd23);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
